// File: rtl/regfile_wb_arbiter_pkg.sv
// ------------------------------------------------------------------------
// regfile_wb_arbiter_pkg : shared types for the register-file write arbiter
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package regfile_wb_arbiter_pkg;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic          live;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  // Register 0 is hardwired zero, so it is never a real write target.
  function automatic logic is_writable(input logic [AW-1:0] addr);
    return addr != REG_ZERO;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
// ------------------------------------------------------------------------
// regfile_wb_arbiter_if : requester, register-file and hazard signals
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface regfile_wb_arbiter_if;

  logic                                 a_we;
  logic [regfile_wb_arbiter_pkg::AW-1:0] a_waddr;
  logic [regfile_wb_arbiter_pkg::DW-1:0] a_wdata;
  logic                                 a_stall;

  logic                                 b_valid;
  logic                                 b_ready;
  logic [regfile_wb_arbiter_pkg::AW-1:0] b_waddr;
  logic [regfile_wb_arbiter_pkg::DW-1:0] b_wdata;

  logic                                 rf_we;
  logic [regfile_wb_arbiter_pkg::AW-1:0] rf_waddr;
  logic [regfile_wb_arbiter_pkg::DW-1:0] rf_wdata;

  logic [regfile_wb_arbiter_pkg::AW-1:0] rreg_a;
  logic [regfile_wb_arbiter_pkg::AW-1:0] rreg_b;
  logic                                 rd_busy_a;
  logic                                 rd_busy_b;

  modport master (
    output a_we, a_waddr, a_wdata,
    input  a_stall,
    output b_valid, b_waddr, b_wdata,
    input  b_ready,
    input  rf_we, rf_waddr, rf_wdata,
    output rreg_a, rreg_b,
    input  rd_busy_a, rd_busy_b
  );

  modport slave (
    input  a_we, a_waddr, a_wdata,
    output a_stall,
    input  b_valid, b_waddr, b_wdata,
    output b_ready,
    output rf_we, rf_waddr, rf_wdata,
    input  rreg_a, rreg_b,
    output rd_busy_a, rd_busy_b
  );

endinterface

`default_nettype wire

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// ------------------------------------------------------------------------
// wb_fifo : port-B write-back FIFO with kill-by-address and dead-head pop
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  push,
  input  wire wb_entry_t             push_entry,
  input  wire logic                  issue_pop,
  input  wire logic                  kill_en,
  input  wire logic [AW-1:0]         kill_addr,
  output wb_entry_t                  head,
  output wb_entry_t [DEPTH-1:0]      entries,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] r_mem;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic                  w_push;
  logic                  w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == CW'(DEPTH));
  assign head    = r_mem[r_rd_ptr];
  assign entries = r_mem;

  assign w_push = push && !full;
  // A dead head leaves without being asked, so it never holds up the queue.
  assign w_pop  = !empty && (issue_pop || !r_mem[r_rd_ptr].live);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Popped slots drop live so that live always implies occupied.
      for (int i = 0; i < DEPTH; i++) begin
        if ((kill_en && r_mem[i].addr == kill_addr) ||
            (w_pop && PW'(i) == r_rd_ptr)) begin
          r_mem[i].live <= 1'b0;
        end
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_entry;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ------------------------------------------------------------------------
// regfile_wb_arbiter : shares the register-file write port between A and B
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic           clk,
  input  wire logic           rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int            SW         = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_entries;
  wb_entry_t             w_push_entry;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_head_live;
  logic                  w_a_req;
  logic                  w_stall;
  logic                  w_kill;
  grant_e                w_grant;
  wb_req_t               w_issue;
  wb_req_t               r_out;
  logic [SW-1:0]         r_starve;
  logic                  w_hit_a;
  logic                  w_hit_b;

  assign w_head_live = !w_empty && w_head.live;
  assign w_a_req     = bus.a_we && is_writable(bus.a_waddr);
  assign w_stall     = (r_starve == STARVE_MAX);
  assign w_kill      = (w_grant == GNT_A);

  always_comb begin
    w_grant = GNT_NONE;
    if (w_stall) begin
      if (w_head_live) w_grant = GNT_B;
    end else if (w_a_req) begin
      w_grant = GNT_A;
    end else if (w_head_live) begin
      w_grant = GNT_B;
    end
  end

  always_comb begin
    w_issue = '0;
    case (w_grant)
      GNT_A:   w_issue = '{we: 1'b1, addr: bus.a_waddr, data: bus.a_wdata};
      GNT_B:   w_issue = '{we: 1'b1, addr: w_head.addr, data: w_head.data};
      default: w_issue = '0;
    endcase
  end

  // A B result landing alongside an A write to the same register is older, so it is stored dead.
  always_comb begin
    w_push_entry      = '0;
    w_push_entry.addr = bus.b_waddr;
    w_push_entry.data = bus.b_wdata;
    w_push_entry.live = is_writable(bus.b_waddr) && !(w_kill && bus.b_waddr == bus.a_waddr);
  end

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (bus.b_valid && !w_full),
    .push_entry (w_push_entry),
    .issue_pop  (w_grant == GNT_B),
    .kill_en    (w_kill),
    .kill_addr  (bus.a_waddr),
    .head       (w_head),
    .entries    (w_entries),
    .empty      (w_empty),
    .full       (w_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (!w_head_live || w_grant == GNT_B) begin
      r_starve <= '0;
    end else begin
      r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out.we <= w_issue.we;
      if (w_issue.we) begin
        r_out.addr <= w_issue.addr;
        r_out.data <= w_issue.data;
      end
    end
  end

  always_comb begin
    w_hit_a = r_out.we && (r_out.addr == bus.rreg_a);
    w_hit_b = r_out.we && (r_out.addr == bus.rreg_b);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_entries[i].live && w_entries[i].addr == bus.rreg_a) w_hit_a = 1'b1;
      if (w_entries[i].live && w_entries[i].addr == bus.rreg_b) w_hit_b = 1'b1;
    end
  end

  assign bus.a_stall   = w_stall;
  assign bus.b_ready   = !w_full;
  assign bus.rf_we     = r_out.we;
  assign bus.rf_waddr  = r_out.addr;
  assign bus.rf_wdata  = r_out.data;
  assign bus.rd_busy_a = is_writable(bus.rreg_a) && w_hit_a;
  assign bus.rd_busy_b = is_writable(bus.rreg_b) && w_hit_b;

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ------------------------------------------------------------------------
// tb_regfile_wb_arbiter : directed scoreboard bench for regfile_wb_arbiter
// Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int            cyc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every register-file write is matched in order against the expected queue.
  always @(negedge clk) begin
    if (!rst && bus.rf_we === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: cyc %0d got r%0d=%h, required no write",
                 cyc, bus.rf_waddr, bus.rf_wdata);
      end else begin
        m_e = exp_q.pop_front();
        if (m_e.cyc != cyc || m_e.addr !== bus.rf_waddr || m_e.data !== bus.rf_wdata) begin
          n_bad++;
          $display("FAIL rf_write: got cyc %0d r%0d=%h, required cyc %0d r%0d=%h",
                   cyc, bus.rf_waddr, bus.rf_wdata, m_e.cyc, m_e.addr, m_e.data);
        end
      end
    end else if (!rst && exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
      n_cmp++;
      n_bad++;
      m_e = exp_q.pop_front();
      $display("FAIL missing_write: got rf_we=%b at cyc %0d, required r%0d=%h at cyc %0d",
               bus.rf_we, cyc, m_e.addr, m_e.data, m_e.cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expw(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{c, a, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.a_we    = 1'b0;
    bus.a_waddr = '0;
    bus.a_wdata = '0;
    bus.b_valid = 1'b0;
    bus.b_waddr = '0;
    bus.b_wdata = '0;
  endtask

  task automatic drive_a(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.a_we    = 1'b1;
    bus.a_waddr = a;
    bus.a_wdata = d;
  endtask

  task automatic drive_b(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.b_valid = 1'b1;
    bus.b_waddr = a;
    bus.b_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish within 100000 time units");
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] cur;
    idle();
    bus.rreg_a = '0;
    bus.rreg_b = '0;

    // Reset state
    tick();
    tick();
    chk("reset_rf_we",    32'(bus.rf_we), 32'd0);
    chk("reset_rf_waddr", 32'(bus.rf_waddr), 32'd0);
    chk("reset_rf_wdata", bus.rf_wdata, 32'd0);
    chk("reset_a_stall",  32'(bus.a_stall), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_reset_b_ready", 32'(bus.b_ready), 32'd1);

    // A alone: r5 = 0x1234, visible next cycle
    tick();
    drive_a(5'd5, 32'h1234);
    expw(cyc + 1, 5'd5, 32'h1234);
    tick();
    idle();
    bus.rreg_a = 5'd5;
    #1;
    chk("a_alone_busy", 32'(bus.rd_busy_a), 32'd1);
    tick();
    #1;
    chk("a_alone_busy_clear", 32'(bus.rd_busy_a), 32'd0);
    bus.rreg_a = '0;

    // B back-to-back with A idle: r3 then r4 drain on consecutive cycles
    tick();
    drive_b(5'd3, 32'hA);
    expw(cyc + 2, 5'd3, 32'hA);
    tick();
    drive_b(5'd4, 32'hB);
    expw(cyc + 2, 5'd4, 32'hB);
    tick();
    idle();
    tick();
    tick();

    // FIFO filled while A holds the port; b_valid held across not-ready
    drive_a(5'd12, 32'h12C);
    drive_b(5'd13, 32'hD);
    expw(cyc + 1, 5'd12, 32'h12C);
    tick();
    drive_a(5'd16, 32'h16);
    drive_b(5'd14, 32'hE);
    expw(cyc + 1, 5'd16, 32'h16);
    tick();
    idle();
    drive_b(5'd15, 32'hF);
    bus.rreg_a = 5'd14;
    #1;
    chk("full_b_ready", 32'(bus.b_ready), 32'd0);
    chk("full_busy_r14", 32'(bus.rd_busy_a), 32'd1);
    expw(cyc + 1, 5'd13, 32'hD);
    tick();
    #1;
    chk("after_pop_b_ready", 32'(bus.b_ready), 32'd1);
    expw(cyc + 1, 5'd14, 32'hE);
    expw(cyc + 2, 5'd15, 32'hF);
    tick();
    idle();
    bus.rreg_a = '0;
    tick();
    tick();

    // Starvation: live r7 head vs continuous A traffic; one-cycle stall at the 6th cycle
    cur = 5'd20;
    bus.rreg_b = 5'd7;
    for (int i = 0; i < 8; i++) begin
      drive_a(cur, 32'hA000 + 32'(cur));
      if (i == 0) drive_b(5'd7, 32'h77);
      else        bus.b_valid = 1'b0;
      #1;
      chk("a_stall", 32'(bus.a_stall), 32'(i == 5));
      if (i == 3) chk("starve_busy_r7", 32'(bus.rd_busy_b), 32'd1);
      if (i == 5) begin
        expw(cyc + 1, 5'd7, 32'h77);
      end else begin
        expw(cyc + 1, cur, 32'hA000 + 32'(cur));
        cur = cur + 5'd1;
      end
      tick();
    end
    idle();
    bus.rreg_b = '0;
    tick();
    tick();

    // WAW kill: queued B r9 is superseded by A r9 = 0x55
    drive_a(5'd20, 32'h200);
    drive_b(5'd9, 32'h99);
    expw(cyc + 1, 5'd20, 32'h200);
    tick();
    idle();
    drive_a(5'd9, 32'h55);
    bus.rreg_a = 5'd9;
    #1;
    chk("waw_busy_queued", 32'(bus.rd_busy_a), 32'd1);
    expw(cyc + 1, 5'd9, 32'h55);
    tick();
    idle();
    #1;
    chk("waw_busy_commit", 32'(bus.rd_busy_a), 32'd1);
    tick();
    #1;
    chk("waw_busy_clear", 32'(bus.rd_busy_a), 32'd0);
    bus.rreg_a = '0;

    // Same-cycle A and B to r11: B is stored dead
    drive_a(5'd11, 32'h66);
    drive_b(5'd11, 32'hBB);
    expw(cyc + 1, 5'd11, 32'h66);
    tick();
    idle();
    bus.rreg_b = 5'd11;
    tick();
    #1;
    chk("same_cycle_dead_busy", 32'(bus.rd_busy_b), 32'd0);
    bus.rreg_b = '0;
    tick();

    // Register zero from both ports: no write, handshake still completes
    drive_a(5'd0, 32'hDEAD);
    drive_b(5'd0, 32'hBEEF);
    bus.rreg_a = 5'd0;
    #1;
    chk("r0_b_ready", 32'(bus.b_ready), 32'd1);
    chk("r0_busy", 32'(bus.rd_busy_a), 32'd0);
    tick();
    idle();
    #1;
    chk("r0_busy_next", 32'(bus.rd_busy_a), 32'd0);
    tick();
    tick();

    // Async reset with two live entries queued and a write on rf_*
    drive_a(5'd21, 32'h21);
    drive_b(5'd22, 32'h22);
    expw(cyc + 1, 5'd21, 32'h21);
    tick();
    drive_a(5'd23, 32'h23);
    drive_b(5'd24, 32'h24);
    tick();
    idle();
    bus.rreg_a = 5'd22;
    #1;
    chk("pre_reset_rf_we", 32'(bus.rf_we), 32'd1);
    chk("pre_reset_busy", 32'(bus.rd_busy_a), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_rf_we", 32'(bus.rf_we), 32'd0);
    chk("async_rst_b_ready", 32'(bus.b_ready), 32'd1);
    chk("async_rst_busy", 32'(bus.rd_busy_a), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_b_ready", 32'(bus.b_ready), 32'd1);
    repeat (4) tick();
    chk("rst_no_stale_busy", 32'(bus.rd_busy_a), 32'd0);
    bus.rreg_a = '0;
    tick();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
